err_blink_coder: RTL and testbench

//  Multi-channel error indicator for the OptoHybrid front-panel LEDs. Latches NCH error sources
//  (sticky) and drives an MXLED-bit LED bank in one of four modes. The default blink-code mode

---
 rtl/err_ind_pkg.sv | 18 +
 rtl/err_ind_prescaler.sv | 27 ++
 rtl/err_blink_coder.sv | 148 ++++++++++++++
 tb/tb_err_blink_coder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/err_ind_pkg.sv
// Shared encodings for the front-panel error LED blocks: FSM states and display modes.
// Pure declarations; no logic, no latency.
package err_ind_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_ON   = 3'd2,
    ST_OFF  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_BLINK  = 2'd0;
  localparam logic [1:0] MODE_ALT    = 2'd1;
  localparam logic [1:0] MODE_DIRECT = 2'd2;
  localparam logic [1:0] MODE_LAMP   = 2'd3;

endpackage

// File: rtl/err_ind_prescaler.sv
// Phase accumulator adding rate+1 per clock; tick pulses one clock after each wrap.
// Free-running, no backpressure; tick period is 2^MXPRE/(rate+1) clocks on average.
module err_ind_prescaler #(
  parameter int MXPRE = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] rate,
  output logic       tick
);

  logic [MXPRE-1:0] acc;
  logic [MXPRE:0]   sum;

  assign sum = {1'b0, acc} + {{(MXPRE-1){1'b0}}, rate} + (MXPRE+1)'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      acc  <= '0;
      tick <= 1'b0;
    end else begin
      acc  <= sum[MXPRE-1:0];
      tick <= sum[MXPRE];
    end
  end

endmodule

// File: rtl/err_blink_coder.sv
// Sticky multi-channel error latch driving an LED bank as blink codes (k+1 flashes for channel k),
// alternating pattern, direct bits or lamp test; q is registered one clock behind state/mode.
module err_blink_coder
  import err_ind_pkg::*;
#(
  parameter int MXLED     = 16,
  parameter int NCH       = 4,
  parameter int MXPRE     = 24,
  parameter int GAP_TICKS = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       rate,
  input  logic [NCH-1:0]   err,
  input  logic             clear,
  input  logic [1:0]       mode,
  output logic [MXLED-1:0] q,
  output logic [NCH-1:0]   err_latched,
  output logic             busy
);

  localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NFW = $clog2(NCH + 1);
  localparam int GW  = $clog2(GAP_TICKS + 1);
  localparam int ND  = (NCH < MXLED) ? NCH : MXLED;

  // Returns {found, index} of the first set bit strictly after p, wrapping; p itself is checked last.
  function automatic logic [PW:0] next_latched(input logic [NCH-1:0] v, input logic [PW-1:0] p);
    logic [PW:0] r;
    int          j;
    r = '0;
    for (int i = NCH; i >= 1; i--) begin
      j = (int'(p) + i) % NCH;
      if (v[j]) r = {1'b1, PW'(j)};
    end
    return r;
  endfunction

  state_t           state, state_n;
  logic [PW-1:0]    ptr, ptr_n;
  logic [NFW-1:0]   nflash, nflash_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic [PW:0]      hit;
  logic             tick;
  logic             alt;
  logic [MXLED-1:0] q_n;

  err_ind_prescaler #(.MXPRE(MXPRE)) u_pre (
    .clock (clock),
    .reset (reset),
    .rate  (rate),
    .tick  (tick)
  );

  assign hit  = next_latched(err_latched, ptr);
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      err_latched <= '0;
      alt         <= 1'b0;
    end else begin
      err_latched <= (err_latched & ~{NCH{clear}}) | err;
      if (tick && |err_latched) alt <= ~alt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      ptr    <= PW'(NCH - 1);
      nflash <= '0;
      gcnt   <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      nflash <= nflash_n;
      gcnt   <= gcnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    nflash_n = nflash;
    gcnt_n   = gcnt;
    // A clear that is not fighting a live error abandons whatever code is playing.
    if (clear && !(|err)) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (|err_latched) state_n = ST_SCAN;
        ST_SCAN: begin
          if (hit[PW]) begin
            ptr_n    = hit[PW-1:0];
            nflash_n = NFW'(hit[PW-1:0]) + NFW'(1);
            state_n  = ST_ON;
          end else begin
            state_n  = ST_IDLE;
          end
        end
        ST_ON: begin
          if (tick) begin
            nflash_n = nflash - NFW'(1);
            state_n  = ST_OFF;
          end
        end
        ST_OFF: begin
          if (tick) begin
            if (nflash == '0) begin
              gcnt_n  = GW'(GAP_TICKS);
              state_n = ST_GAP;
            end else begin
              state_n = ST_ON;
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            gcnt_n = gcnt - GW'(1);
            if (gcnt == GW'(1)) state_n = ST_SCAN;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    q_n = '0;
    case (mode)
      MODE_BLINK: if (state == ST_ON) q_n = '1;
      MODE_ALT: begin
        if (|err_latched) begin
          for (int i = 0; i < MXLED; i++) q_n[i] = (i % 2 == 1) ? alt : ~alt;
        end
      end
      MODE_DIRECT: q_n[ND-1:0] = err_latched[ND-1:0];
      default:     q_n = '1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) q <= '0;
    else       q <= q_n;
  end

endmodule

// File: tb/tb_err_blink_coder.sv
// Randomised bench for err_blink_coder with a segment-list reference model and a queued scoreboard.
module tb_err_blink_coder;

  localparam int MXLED = 16;
  localparam int NCH   = 4;
  localparam int MXPRE = 4;
  localparam int GAPT  = 3;
  localparam int WRAP  = 1 << MXPRE;

  localparam int P_IDLE = 0, P_SCAN = 1, P_PLAY = 2;
  localparam int SEG_DARK = 0, SEG_LIT = 1;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       rate;
  logic [NCH-1:0]   err;
  logic             clear;
  logic [1:0]       mode;
  logic [MXLED-1:0] q;
  logic [NCH-1:0]   err_latched;
  logic             busy;

  err_blink_coder #(.MXLED(MXLED), .NCH(NCH), .MXPRE(MXPRE), .GAP_TICKS(GAPT)) dut (
    .clock       (clock),
    .reset       (reset),
    .rate        (rate),
    .err         (err),
    .clear       (clear),
    .mode        (mode),
    .q           (q),
    .err_latched (err_latched),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [MXLED-1:0] q;
    logic [NCH-1:0]   el;
    logic             busy;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: the blink sequence is a list of segments, each ending on a prescaler tick.
  int               m_acc;
  bit               m_tick;
  logic [NCH-1:0]   m_el;
  bit               m_alt;
  int               m_ptr;
  int               m_phase;
  int               plan[$];
  logic [MXLED-1:0] m_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step();
    logic [MXLED-1:0] nq;
    int found, sum, idx;
    exp_t e;
    if (reset) begin
      m_acc = 0; m_tick = 0; m_el = '0; m_alt = 0; m_ptr = NCH - 1;
      m_phase = P_IDLE; plan.delete(); m_q = '0;
    end else begin
      nq = '0;
      case (mode)
        2'd0: if (m_phase == P_PLAY && plan[0] == SEG_LIT) nq = '1;
        2'd1: if (m_el != 0) nq = m_alt ? 16'hAAAA : 16'h5555;
        2'd2: nq = {{(MXLED-NCH){1'b0}}, m_el};
        default: nq = '1;
      endcase
      if (m_tick && m_el != 0) m_alt = !m_alt;
      if (clear && err == 0) begin
        m_phase = P_IDLE;
        plan.delete();
      end else begin
        case (m_phase)
          P_IDLE: if (m_el != 0) m_phase = P_SCAN;
          P_SCAN: begin
            found = -1;
            for (int k = 1; k <= NCH; k++) begin
              idx = (m_ptr + k) % NCH;
              if (found < 0 && m_el[idx]) found = idx;
            end
            if (found >= 0) begin
              m_ptr = found;
              for (int f = 0; f <= found; f++) begin
                plan.push_back(SEG_LIT);
                plan.push_back(SEG_DARK);
              end
              repeat (GAPT) plan.push_back(SEG_DARK);
              m_phase = P_PLAY;
            end else begin
              m_phase = P_IDLE;
            end
          end
          default: begin
            if (m_tick) begin
              void'(plan.pop_front());
              if (plan.size() == 0) m_phase = P_SCAN;
            end
          end
        endcase
      end
      m_el   = (m_el & ~{NCH{clear}}) | err;
      sum    = m_acc + int'(rate) + 1;
      m_tick = (sum >= WRAP);
      m_acc  = sum % WRAP;
      m_q    = nq;
    end
    e.q = m_q; e.el = m_el; e.busy = (m_phase != P_IDLE);
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  function automatic bit cond_hit(input int which);
    if (m_phase != P_PLAY) return 0;
    if (which == 0) return (m_ptr == 3 && plan[0] == SEG_LIT);
    return (plan.size() <= GAPT);
  endfunction

  task automatic wait_cond(input int which, input string name);
    int n = 0;
    while (!cond_hit(which) && n < 400) begin
      cyc();
      n++;
    end
    n_vec++;
    if (!cond_hit(which)) begin
      n_bad++;
      $display("FAIL %s: condition not reached, got timeout, expected hit within 400 clocks", name);
    end
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("q", 32'(q), 32'(e.q));
      check("err_latched", 32'(err_latched), 32'(e.el));
      check("busy", 32'(busy), 32'(e.busy));
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rate = 2'd0; err = '0; clear = 1'b0; mode = 2'd0;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (200) cyc();

    // Single channel 2 code at fast rate.
    rate = 2'd3; err = 4'b0100; cyc(); err = '0;
    repeat (100) cyc();

    // Channels 0 and 3: pointer wraps 3 -> 0.
    clear = 1'b1; cyc(); clear = 1'b0;
    err = 4'b1001; cyc(); err = '0;
    wait_cond(0, "code3_on");
    clear = 1'b1; cyc(); clear = 1'b0;
    repeat (5) cyc();

    // Clear racing a live error keeps that bit.
    err = 4'b1000; cyc(); err = '0; repeat (3) cyc();
    clear = 1'b1; err = 4'b0010; cyc(); clear = 1'b0; err = '0;
    repeat (60) cyc();

    // Display modes, then back to blink without restarting.
    err = 4'b1010; cyc(); err = '0; clear = 1'b1; err = 4'b1010; cyc(); clear = 1'b0; err = '0;
    mode = 2'd2; repeat (10) cyc();
    mode = 2'd3; repeat (10) cyc();
    mode = 2'd0; repeat (40) cyc();

    // Rate sweep in alternating mode exposes tick spacing on q.
    mode = 2'd1;
    for (int r = 0; r < 4; r++) begin
      rate = 2'(r);
      repeat (64) cyc();
    end

    // Reset in the middle of a gap.
    mode = 2'd0; rate = 2'd3;
    wait_cond(1, "gap_reached");
    reset = 1'b1; cyc(); reset = 1'b0;
    repeat (10) cyc();

    // Random soak.
    for (int n = 0; n < 2500; n++) begin
      err   = ($urandom_range(0, 39) == 0) ? 4'($urandom) : '0;
      clear = ($urandom_range(0, 149) == 0);
      reset = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 79) == 0) rate = 2'($urandom);
      cyc();
    end
    reset = 1'b0; err = '0; clear = 1'b0;
    repeat (4) cyc();
    @(posedge clock); #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
